// File: rtl/jtcps15_volume.sv
// Output volume stage after the CPS1.5 QSound block: 16-step 2 dB attenuation, 2-clock latency.
// Gain steps wait for a zero crossing or a timeout. There is no backpressure: one sample is accepted per clock.
module jtcps15_volume #(
    parameter logic [3:0] DEF_ATT = 4'd4,
    parameter int         ZC_TMO  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vol_up,
    input  logic        vol_down,
    input  logic        sample_in,
    input  logic [15:0] left_in,
    input  logic [15:0] right_in,
    output logic [15:0] left_out,
    output logic [15:0] right_out,
    output logic        sample_out,
    output logic [3:0]  att,
    output logic        clip
);

    localparam logic [7:0] TMO_LAST = 8'(ZC_TMO - 1);

    // Q1.8 gain per attenuation index; index 0 is exact unity
    function automatic logic [8:0] gain_rom(input logic [3:0] idx);
        logic [8:0] g;
        case (idx)
            4'd0:    g = 9'd256;
            4'd1:    g = 9'd203;
            4'd2:    g = 9'd161;
            4'd3:    g = 9'd128;
            4'd4:    g = 9'd102;
            4'd5:    g = 9'd81;
            4'd6:    g = 9'd64;
            4'd7:    g = 9'd51;
            4'd8:    g = 9'd40;
            4'd9:    g = 9'd32;
            4'd10:   g = 9'd26;
            4'd11:   g = 9'd20;
            4'd12:   g = 9'd16;
            4'd13:   g = 9'd13;
            4'd14:   g = 9'd10;
            default: g = 9'd8;
        endcase
        return g;
    endfunction

    // Returns {saturated, value}; the arithmetic shift drops the Q1.8 fraction
    function automatic logic [16:0] shift_sat(input logic signed [24:0] p);
        logic signed [24:0] sh;
        logic               pos_ovf;
        logic               neg_ovf;
        logic [16:0]        r;
        sh      = p >>> 8;
        pos_ovf = ~sh[24] & (|sh[23:15]);
        neg_ovf =  sh[24] & ~(&sh[23:15]);
        if (pos_ovf)      r = {1'b1, 16'h7fff};
        else if (neg_ovf) r = {1'b1, 16'h8000};
        else              r = {1'b0, sh[15:0]};
        return r;
    endfunction

    logic        up_q;
    logic        down_q;
    logic        up_edge;
    logic        down_edge;
    logic [3:0]  att_tgt;
    logic [3:0]  att_tgt_nxt;
    logic [3:0]  att_nxt;
    logic [7:0]  tmo_cnt;
    logic [7:0]  tmo_nxt;
    logic        sign_l;
    logic        sign_r;
    logic        pending;
    logic        cross_l;
    logic        cross_r;
    logic        tmo_hit;
    logic [8:0]  gain;

    logic               s1_vld;
    logic signed [24:0] prod_l;
    logic signed [24:0] prod_r;
    logic [16:0]        res_l;
    logic [16:0]        res_r;

    assign up_edge   = vol_up & ~up_q;
    assign down_edge = vol_down & ~down_q;

    always_comb begin
        att_tgt_nxt = att_tgt;
        if (up_edge && !down_edge && att_tgt != 4'd0)
            att_tgt_nxt = att_tgt - 4'd1;
        else if (down_edge && !up_edge && att_tgt != 4'd15)
            att_tgt_nxt = att_tgt + 4'd1;
    end

    // Pending test uses the registered target, so a key edge on the sample clock waits a sample
    always_comb begin
        pending = (att != att_tgt);
        cross_l = (left_in[15] != sign_l) || (left_in == 16'd0);
        cross_r = (right_in[15] != sign_r) || (right_in == 16'd0);
        tmo_hit = (tmo_cnt == TMO_LAST);
        att_nxt = att;
        tmo_nxt = tmo_cnt;
        if (sample_in) begin
            if (pending && (cross_l || cross_r || tmo_hit)) begin
                att_nxt = (att_tgt > att) ? att + 4'd1 : att - 4'd1;
                tmo_nxt = 8'd0;
            end else if (pending) begin
                tmo_nxt = tmo_cnt + 8'd1;
            end else begin
                tmo_nxt = 8'd0;
            end
        end
    end

    assign gain  = gain_rom(att_nxt);
    assign res_l = shift_sat(prod_l);
    assign res_r = shift_sat(prod_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            att     <= DEF_ATT;
            att_tgt <= DEF_ATT;
            tmo_cnt <= 8'd0;
            sign_l  <= 1'b0;
            sign_r  <= 1'b0;
        end else begin
            up_q    <= vol_up;
            down_q  <= vol_down;
            att_tgt <= att_tgt_nxt;
            att     <= att_nxt;
            tmo_cnt <= tmo_nxt;
            if (sample_in) begin
                sign_l <= left_in[15];
                sign_r <= right_in[15];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            prod_l <= '0;
            prod_r <= '0;
        end else begin
            s1_vld <= sample_in;
            if (sample_in) begin
                prod_l <= $signed({{9{left_in[15]}}, left_in}) * $signed({16'd0, gain});
                prod_r <= $signed({{9{right_in[15]}}, right_in}) * $signed({16'd0, gain});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            left_out   <= 16'd0;
            right_out  <= 16'd0;
            sample_out <= 1'b0;
            clip       <= 1'b0;
        end else begin
            sample_out <= s1_vld;
            clip       <= s1_vld & (res_l[16] | res_r[16]);
            if (s1_vld) begin
                left_out  <= res_l[15:0];
                right_out <= res_r[15:0];
            end
        end
    end

endmodule
